// File: rtl/mc_issue_scoreboard_if.sv
// Issue/completion/status bundle between IDU1, the multi-cycle EXU units and the scoreboard.
// Master drives the instruction and done pulses; slave (the scoreboard) drives stall and status.
interface mc_issue_scoreboard_if #(
  parameter int MAC_DEPTH = 2
);
  localparam int MAC_CW = $clog2(MAC_DEPTH + 1);

  logic              issue_valid;
  logic              issue_mul;
  logic              issue_mac;
  logic              issue_div;
  logic              issue_load;
  logic              issue_store;
  logic              issue_rs1_en;
  logic [4:0]        issue_rs1_addr;
  logic              issue_rs2_en;
  logic [4:0]        issue_rs2_addr;
  logic              issue_rd_en;
  logic [4:0]        issue_rd_addr;
  logic              pipe_flush;
  logic              mul_done;
  logic              mac_done;
  logic              div_done;
  logic              lsu_done;
  logic              issue_stall;
  logic [31:0]       pending_mask;
  logic              mul_busy;
  logic              div_busy;
  logic              lsu_busy;
  logic [MAC_CW-1:0] mac_count;
  logic              sb_err;

  modport master (
    output issue_valid, issue_mul, issue_mac, issue_div, issue_load, issue_store,
           issue_rs1_en, issue_rs1_addr, issue_rs2_en, issue_rs2_addr,
           issue_rd_en, issue_rd_addr, pipe_flush,
           mul_done, mac_done, div_done, lsu_done,
    input  issue_stall, pending_mask, mul_busy, div_busy, lsu_busy, mac_count, sb_err
  );

  modport slave (
    input  issue_valid, issue_mul, issue_mac, issue_div, issue_load, issue_store,
           issue_rs1_en, issue_rs1_addr, issue_rs2_en, issue_rs2_addr,
           issue_rd_en, issue_rd_addr, pipe_flush,
           mul_done, mac_done, div_done, lsu_done,
    output issue_stall, pending_mask, mul_busy, div_busy, lsu_busy, mac_count, sb_err
  );
endinterface

// File: rtl/mc_issue_scoreboard.sv
// Issue-side hazard scoreboard for the multi-cycle units (MUL, MAC, DIV, LSU).
// Tracks owed destination registers and unit occupancy; raises one stall for RAW/WAW/structural hazards.
module mc_issue_scoreboard #(
  parameter int MAC_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mc_issue_scoreboard_if.slave    sb
);
  localparam int MAC_CW = $clog2(MAC_DEPTH + 1);
  localparam int MAC_PW = (MAC_DEPTH > 1) ? $clog2(MAC_DEPTH) : 1;

  logic [31:0]       pending_q, pending_d;
  logic              mul_busy_q, mul_busy_d;
  logic              div_busy_q, div_busy_d;
  logic              lsu_busy_q, lsu_busy_d;
  logic [4:0]        mul_rd_q, mul_rd_d;
  logic [4:0]        div_rd_q, div_rd_d;
  logic [4:0]        lsu_rd_q, lsu_rd_d;
  logic [MAC_CW-1:0] mac_count_q, mac_count_d;
  logic [MAC_PW-1:0] mac_wr_q, mac_wr_d, mac_rd_q, mac_rd_d;
  logic              err_q, err_d;
  logic [4:0]        mac_fifo_q [MAC_DEPTH];

  logic [4:0] flags;
  logic       multi, raw, waw, struct_haz, stall, accept;
  logic       sets_rd, mac_push, mac_pop;
  logic [4:0] owed_rd;

  function automatic logic [MAC_PW-1:0] ptr_inc(input logic [MAC_PW-1:0] p);
    return (p == MAC_PW'(MAC_DEPTH - 1)) ? '0 : p + MAC_PW'(1);
  endfunction

  assign flags = {sb.issue_mul, sb.issue_mac, sb.issue_div, sb.issue_load, sb.issue_store};
  assign multi = (flags & (flags - 5'd1)) != 5'd0;

  // Hazards look only at registered state; a done pulse releases the dependent op one cycle later.
  assign raw = (sb.issue_rs1_en & pending_q[sb.issue_rs1_addr])
             | (sb.issue_rs2_en & pending_q[sb.issue_rs2_addr]);
  assign waw = sb.issue_rd_en & pending_q[sb.issue_rd_addr];
  assign struct_haz = (sb.issue_mul & mul_busy_q) | (sb.issue_div & div_busy_q)
                    | ((sb.issue_load | sb.issue_store) & lsu_busy_q)
                    | (sb.issue_mac & (mac_count_q == MAC_CW'(MAC_DEPTH)));
  assign stall   = sb.issue_valid & ~multi & (raw | waw | struct_haz);
  assign accept  = sb.issue_valid & ~stall & ~sb.pipe_flush & ~multi;
  assign sets_rd = sb.issue_rd_en & (sb.issue_rd_addr != 5'd0)
                 & (sb.issue_mul | sb.issue_mac | sb.issue_div | sb.issue_load);
  assign owed_rd  = sets_rd ? sb.issue_rd_addr : 5'd0;
  assign mac_push = accept & sb.issue_mac;
  assign mac_pop  = sb.mac_done & (mac_count_q != '0);

  // NOTE: every _d gets a default first, so no path through this block can infer a latch.
  always_comb begin
    pending_d   = pending_q;
    mul_busy_d  = mul_busy_q;
    div_busy_d  = div_busy_q;
    lsu_busy_d  = lsu_busy_q;
    mul_rd_d    = mul_rd_q;
    div_rd_d    = div_rd_q;
    lsu_rd_d    = lsu_rd_q;
    mac_wr_d    = mac_wr_q;
    mac_rd_d    = mac_rd_q;
    err_d       = err_q;
    mac_count_d = mac_count_q + MAC_CW'(mac_push) - MAC_CW'(mac_pop);

    if (sb.mul_done) begin
      if (mul_busy_q) begin
        mul_busy_d = 1'b0;
        pending_d[mul_rd_q] = 1'b0;
      end else err_d = 1'b1;
    end
    if (sb.div_done) begin
      if (div_busy_q) begin
        div_busy_d = 1'b0;
        pending_d[div_rd_q] = 1'b0;
      end else err_d = 1'b1;
    end
    if (sb.lsu_done) begin
      if (lsu_busy_q) begin
        lsu_busy_d = 1'b0;
        pending_d[lsu_rd_q] = 1'b0;
      end else err_d = 1'b1;
    end
    if (sb.mac_done) begin
      if (mac_pop) begin
        pending_d[mac_fifo_q[mac_rd_q]] = 1'b0;
        mac_rd_d = ptr_inc(mac_rd_q);
      end else err_d = 1'b1;
    end
    if (sb.issue_valid & multi) err_d = 1'b1;

    if (accept) begin
      if (sb.issue_mul) begin mul_busy_d = 1'b1; mul_rd_d = owed_rd; end
      if (sb.issue_div) begin div_busy_d = 1'b1; div_rd_d = owed_rd; end
      if (sb.issue_load | sb.issue_store) begin lsu_busy_d = 1'b1; lsu_rd_d = owed_rd; end
      if (sb.issue_mac) mac_wr_d = ptr_inc(mac_wr_q);
      // Applied after the clears so a same-cycle set of the same register wins.
      if (sets_rd) pending_d[sb.issue_rd_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      mul_busy_q  <= 1'b0;
      div_busy_q  <= 1'b0;
      lsu_busy_q  <= 1'b0;
      mul_rd_q    <= '0;
      div_rd_q    <= '0;
      lsu_rd_q    <= '0;
      mac_count_q <= '0;
      mac_wr_q    <= '0;
      mac_rd_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pending_q   <= pending_d;
      mul_busy_q  <= mul_busy_d;
      div_busy_q  <= div_busy_d;
      lsu_busy_q  <= lsu_busy_d;
      mul_rd_q    <= mul_rd_d;
      div_rd_q    <= div_rd_d;
      lsu_rd_q    <= lsu_rd_d;
      mac_count_q <= mac_count_d;
      mac_wr_q    <= mac_wr_d;
      mac_rd_q    <= mac_rd_d;
      err_q       <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; resetting the pointers and count already empties it.
  always_ff @(posedge clk) begin
    if (rst_n && mac_push) mac_fifo_q[mac_wr_q] <= owed_rd;
  end

  assign sb.issue_stall  = stall;
  assign sb.pending_mask = pending_q;
  assign sb.mul_busy     = mul_busy_q;
  assign sb.div_busy     = div_busy_q;
  assign sb.lsu_busy     = lsu_busy_q;
  assign sb.mac_count    = mac_count_q;
  assign sb.sb_err       = err_q;
endmodule

// File: tb/tb_mc_issue_scoreboard.sv
// Directed bench for mc_issue_scoreboard (MAC_DEPTH=2) with hand-computed expectations.
module tb_mc_issue_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mc_issue_scoreboard_if #(.MAC_DEPTH(2)) sbif ();
  mc_issue_scoreboard #(.MAC_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .sb(sbif.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sbif.issue_valid = 0; sbif.issue_mul = 0; sbif.issue_mac = 0; sbif.issue_div = 0;
    sbif.issue_load = 0; sbif.issue_store = 0; sbif.issue_rs1_en = 0; sbif.issue_rs1_addr = 0;
    sbif.issue_rs2_en = 0; sbif.issue_rs2_addr = 0; sbif.issue_rd_en = 0; sbif.issue_rd_addr = 0;
    sbif.pipe_flush = 0; sbif.mul_done = 0; sbif.mac_done = 0; sbif.div_done = 0; sbif.lsu_done = 0;
  endtask

  // unit = {mul,mac,div,load,store}; a read address of 0 means that source is unused
  task automatic present(input logic [4:0] unit, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic rd_en, input logic [4:0] rd);
    sbif.issue_valid = 1;
    {sbif.issue_mul, sbif.issue_mac, sbif.issue_div, sbif.issue_load, sbif.issue_store} = unit;
    sbif.issue_rs1_en = (rs1 != 0); sbif.issue_rs1_addr = rs1;
    sbif.issue_rs2_en = (rs2 != 0); sbif.issue_rs2_addr = rs2;
    sbif.issue_rd_en = rd_en; sbif.issue_rd_addr = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pend"}, sbif.pending_mask, 32'h0);
    check({tag, "_busy"}, {29'd0, sbif.mul_busy, sbif.div_busy, sbif.lsu_busy}, 32'h0);
    check({tag, "_cnt"}, 32'(sbif.mac_count), 32'h0);
    check({tag, "_err"}, 32'(sbif.sb_err), 32'h0);
  endtask

  localparam logic [4:0] U_ALU = 5'b00000, U_MUL = 5'b10000, U_MAC = 5'b01000,
                         U_DIV = 5'b00100, U_LD = 5'b00010, U_ST = 5'b00001;

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    check_all_zero("reset");

    // MUL x5 then dependent ALU reading x5
    present(U_MUL, 5'd1, 5'd0, 1, 5'd5);
    check("mul_issue_stall", 32'(sbif.issue_stall), 0);
    tick();
    check("mul_pend", sbif.pending_mask, 32'h0000_0020);
    check("mul_busy", 32'(sbif.mul_busy), 1);
    present(U_ALU, 5'd5, 5'd0, 1, 5'd10);
    check("raw_stall", 32'(sbif.issue_stall), 1);
    tick();
    present(U_ALU, 5'd5, 5'd0, 1, 5'd10);
    sbif.mul_done = 1; #1;
    check("raw_no_bypass", 32'(sbif.issue_stall), 1);
    tick();
    present(U_ALU, 5'd5, 5'd0, 1, 5'd10);
    check("raw_release", 32'(sbif.issue_stall), 0);
    check("mul_pend_clr", sbif.pending_mask, 32'h0);
    check("mul_busy_clr", 32'(sbif.mul_busy), 0);
    tick();
    check("alu_no_pend", sbif.pending_mask, 32'h0);

    // MAC x6, MAC x7, third MAC x8 stalls until oldest completes
    present(U_MAC, 5'd0, 5'd0, 1, 5'd6); tick();
    present(U_MAC, 5'd0, 5'd0, 1, 5'd7);
    check("mac2_stall", 32'(sbif.issue_stall), 0);
    tick();
    check("mac_cnt2", 32'(sbif.mac_count), 2);
    check("mac_pend67", sbif.pending_mask, 32'h0000_00C0);
    present(U_MAC, 5'd0, 5'd0, 1, 5'd8);
    check("mac_full_stall", 32'(sbif.issue_stall), 1);
    sbif.mac_done = 1; #1;
    check("mac_full_no_bypass", 32'(sbif.issue_stall), 1);
    tick();
    check("mac_pop_pend", sbif.pending_mask, 32'h0000_0080);
    check("mac_cnt1", 32'(sbif.mac_count), 1);
    present(U_MAC, 5'd0, 5'd0, 1, 5'd8);
    check("mac3_go", 32'(sbif.issue_stall), 0);
    tick();
    check("mac_cnt2b", 32'(sbif.mac_count), 2);
    check("mac_pend78", sbif.pending_mask, 32'h0000_0180);

    // drain x7, then same-cycle pop of x8 and push of x9
    sbif.mac_done = 1; tick();
    check("mac_pend8", sbif.pending_mask, 32'h0000_0100);
    present(U_MAC, 5'd0, 5'd0, 1, 5'd9);
    sbif.mac_done = 1; #1;
    check("mac_pushpop_stall", 32'(sbif.issue_stall), 0);
    tick();
    check("mac_pushpop_cnt", 32'(sbif.mac_count), 1);
    check("mac_pushpop_pend", sbif.pending_mask, 32'h0000_0200);
    sbif.mac_done = 1; tick();
    check("mac_head_new", sbif.pending_mask, 32'h0);
    check("mac_cnt0", 32'(sbif.mac_count), 0);
    check("mac_err0", 32'(sbif.sb_err), 0);

    // spurious div_done
    sbif.div_done = 1; tick();
    check("spur_err", 32'(sbif.sb_err), 1);
    check("spur_pend", sbif.pending_mask, 32'h0);
    check("spur_busy", 32'(sbif.div_busy), 0);
    tick();
    check("spur_sticky", 32'(sbif.sb_err), 1);

    rst_n = 0; tick(); rst_n = 1;
    check_all_zero("reset2");

    // store, then load to x0
    present(U_ST, 5'd2, 5'd3, 0, 5'd0); tick();
    check("st_busy", 32'(sbif.lsu_busy), 1);
    check("st_pend", sbif.pending_mask, 32'h0);
    present(U_LD, 5'd2, 5'd0, 1, 5'd0);
    check("lsu_struct", 32'(sbif.issue_stall), 1);
    sbif.lsu_done = 1; tick();
    present(U_LD, 5'd2, 5'd0, 1, 5'd0); tick();
    check("ld_x0_pend", sbif.pending_mask, 32'h0);
    check("ld_x0_busy", 32'(sbif.lsu_busy), 1);
    sbif.lsu_done = 1; tick();
    check("ld_done_busy", 32'(sbif.lsu_busy), 0);

    // DIV x9; ALU writing x9 waits (WAW)
    present(U_DIV, 5'd1, 5'd2, 1, 5'd9); tick();
    check("div_pend", sbif.pending_mask, 32'h0000_0200);
    present(U_ALU, 5'd0, 5'd0, 1, 5'd9);
    check("waw_stall", 32'(sbif.issue_stall), 1);
    sbif.div_done = 1; tick();
    present(U_ALU, 5'd0, 5'd0, 1, 5'd9);
    check("waw_release", 32'(sbif.issue_stall), 0);
    tick();
    check("div_err", 32'(sbif.sb_err), 0);

    // flushed MUL not accepted
    present(U_MUL, 5'd0, 5'd0, 1, 5'd4);
    sbif.pipe_flush = 1; tick();
    check("flush_busy", 32'(sbif.mul_busy), 0);
    check("flush_pend", sbif.pending_mask, 32'h0);

    // MUL+DIV flags together: no stall, nothing recorded, error
    present(5'b10100, 5'd0, 5'd0, 1, 5'd11);
    check("multi_stall", 32'(sbif.issue_stall), 0);
    tick();
    check("multi_err", 32'(sbif.sb_err), 1);
    check("multi_busy", {30'd0, sbif.mul_busy, sbif.div_busy}, 32'h0);
    check("multi_pend", sbif.pending_mask, 32'h0);

    rst_n = 0; tick(); rst_n = 1;
    // MUL x3 in flight, then one reset cycle (mul_done during reset ignored)
    present(U_MUL, 5'd0, 5'd0, 1, 5'd3); tick();
    check("mul3_pend", sbif.pending_mask, 32'h0000_0008);
    rst_n = 0; sbif.mul_done = 1; tick(); rst_n = 1;
    check_all_zero("reset3");
    sbif.mul_done = 1; tick();
    check("late_done_err", 32'(sbif.sb_err), 1);
    check("late_done_pend", sbif.pending_mask, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
